// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg
// This package holds the types and constants that the PC fetch unit uses.
//   fetch_state_e : the fetch FSM state encoding. S_TRAP exists only when
//                   PC_MISALIGN_TRAP_EN is defined.
//   INSTR_WIDTH   : the width of an instruction word.
//   PC_INCR       : the sequential PC step, in bytes.
// Configuration macro: PC_MISALIGN_TRAP_EN
package pc_fetch_unit_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_INCR     = 4;

`ifdef PC_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_TRAP  = 3'd4
   } fetch_state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3
   } fetch_state_e;
`endif

endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// This is the instruction fetch unit. It keeps at most one instruction in flight.
// It issues one request per instruction, waits for the data, and holds the
// instruction toward decode until decode consumes it. A branch redirect takes
// priority over the sequential PC at any point in a transaction.
//
// Ports
//   clk, reset         : the clock, and a synchronous active-high reset
//   PC_src_in          : redirect request; branch_target_in is the new PC
//   branch_target_in   : the redirect target
//   imem_req_out       : request valid toward instruction memory
//   imem_addr_out      : request address (the current pc)
//   imem_ready_in      : memory accepts the request this cycle
//   imem_valid_in      : read data returns this cycle
//   imem_rdata_in      : the returned instruction word
//   instr_valid_out    : instr_out and instr_pc_out are valid toward decode
//   instr_out          : the fetched instruction
//   instr_pc_out       : the address of instr_out
//   decode_ready_in    : decode consumes the held instruction
//   misalign_trap_out  : a misaligned redirect target was seen (macro only)
//
// Configuration macro: PC_MISALIGN_TRAP_EN
//   When the macro is defined, a redirect to a target that is not word-aligned
//   enters TRAP. The unit stays in TRAP until reset.
//   When the macro is undefined, the unit clears the two low bits of the target.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | just out of reset; always goes to S_FETCH on the next cycle
// S_FETCH | request at pc is presented, waiting for imem_ready_in
// S_WAIT  | request accepted, waiting for imem_valid_in
// S_HOLD  | instruction presented to decode, waiting for decode_ready_in
// S_TRAP  | misaligned redirect; all activity stops until reset (macro)
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int                  PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   PC_src_in,
   input  logic [PC_WIDTH-1:0]    branch_target_in,
   output logic                   imem_req_out,
   output logic [PC_WIDTH-1:0]    imem_addr_out,
   input  logic                   imem_ready_in,
   input  logic                   imem_valid_in,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
   output logic                   instr_valid_out,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [PC_WIDTH-1:0]    instr_pc_out,
`ifdef PC_MISALIGN_TRAP_EN
   output logic                   misalign_trap_out,
`endif
   input  logic                   decode_ready_in
);

   localparam logic [PC_WIDTH-1:0] C_PC_INCR = PC_WIDTH'(PC_INCR);

   fetch_state_e            r_state;
   fetch_state_e            w_state_next;
   logic [PC_WIDTH-1:0]     r_pc;
   logic [PC_WIDTH-1:0]     r_fetch_pc;
   logic                    r_kill;
   logic [INSTR_WIDTH-1:0]  r_instr;
   logic [PC_WIDTH-1:0]     r_instr_pc;
   logic [PC_WIDTH-1:0]     w_target;

`ifdef PC_MISALIGN_TRAP_EN
   logic w_trap_go;

   // The pc loads the raw target, because the trap reports the real address.
   assign w_target  = branch_target_in;
   assign w_trap_go = PC_src_in && (branch_target_in[1:0] != 2'b00);
`else
   logic w_unused_tgt_lsbs;

   assign w_target          = {branch_target_in[PC_WIDTH-1:2], 2'b00};
   assign w_unused_tgt_lsbs = ^branch_target_in[1:0];
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            w_state_next = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ready_in) begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            // A redirect seen together with the data kills that data at once.
            if (imem_valid_in) begin
               w_state_next = (r_kill || PC_src_in) ? S_FETCH : S_HOLD;
            end
         end
         S_HOLD: begin
            if (PC_src_in || decode_ready_in) begin
               w_state_next = S_FETCH;
            end
         end
`ifdef PC_MISALIGN_TRAP_EN
         S_TRAP: begin
            w_state_next = S_TRAP;
         end
`endif
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
`ifdef PC_MISALIGN_TRAP_EN
      if (w_trap_go && (r_state == S_FETCH || r_state == S_WAIT || r_state == S_HOLD)) begin
         w_state_next = S_TRAP;
      end
`endif
   end

   // Output logic
   always_comb begin
      imem_req_out    = 1'b0;
      instr_valid_out = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_trap_out = 1'b0;
`endif
      case (r_state)
         S_FETCH: imem_req_out    = 1'b1;
         S_HOLD:  instr_valid_out = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
         S_TRAP:  misalign_trap_out = 1'b1;
`endif
         default: ;
      endcase
   end

   assign imem_addr_out = r_pc;
   assign instr_out     = r_instr;
   assign instr_pc_out  = r_instr_pc;

   // Datapath: pc, the in-flight address, the kill flag and the held instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_fetch_pc <= '0;
         r_kill     <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (PC_src_in) begin
                  r_pc <= w_target;
               end else if (imem_ready_in) begin
                  r_pc <= r_pc + C_PC_INCR;
               end
               if (imem_ready_in) begin
                  r_fetch_pc <= r_pc;
                  // The accepted request already targets the wrong path.
                  r_kill     <= PC_src_in;
               end
            end
            S_WAIT: begin
               if (PC_src_in) begin
                  r_pc <= w_target;
               end
               if (imem_valid_in) begin
                  if (!r_kill && !PC_src_in) begin
                     r_instr    <= imem_rdata_in;
                     r_instr_pc <= r_fetch_pc;
                  end
                  r_kill <= 1'b0;
               end else if (PC_src_in) begin
                  r_kill <= 1'b1;
               end
            end
            S_HOLD: begin
               if (PC_src_in) begin
                  r_pc <= w_target;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// This bench drives directed stimulus into pc_fetch_unit (PC_WIDTH=64,
// RESET_PC=0) and checks the outputs one cycle at a time. All expected values
// were worked out by hand.
// Configuration macro: PC_MISALIGN_TRAP_EN (this selects the trap checks)
module tb_pc_fetch_unit;

   logic        clk;
   logic        reset;
   logic        PC_src_in;
   logic [63:0] branch_target_in;
   logic        imem_req_out;
   logic [63:0] imem_addr_out;
   logic        imem_ready_in;
   logic        imem_valid_in;
   logic [31:0] imem_rdata_in;
   logic        instr_valid_out;
   logic [31:0] instr_out;
   logic [63:0] instr_pc_out;
   logic        decode_ready_in;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign_trap_out;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pc_fetch_unit #(
      .PC_WIDTH (64),
      .RESET_PC (64'h0)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .PC_src_in         (PC_src_in),
      .branch_target_in  (branch_target_in),
      .imem_req_out      (imem_req_out),
      .imem_addr_out     (imem_addr_out),
      .imem_ready_in     (imem_ready_in),
      .imem_valid_in     (imem_valid_in),
      .imem_rdata_in     (imem_rdata_in),
      .instr_valid_out   (instr_valid_out),
      .instr_out         (instr_out),
      .instr_pc_out      (instr_pc_out),
`ifdef PC_MISALIGN_TRAP_EN
      .misalign_trap_out (misalign_trap_out),
`endif
      .decode_ready_in   (decode_ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wait until 1 ns after the next rising edge. Both the drive and the sample
   // happen at that point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1);
   end

   initial begin
      reset            = 1'b1;
      PC_src_in        = 1'b0;
      branch_target_in = '0;
      imem_ready_in    = 1'b0;
      imem_valid_in    = 1'b0;
      imem_rdata_in    = '0;
      decode_ready_in  = 1'b0;
      step();
      step();
      check_val("rst_req",       64'(imem_req_out),    64'h0);
      check_val("rst_ivalid",    64'(instr_valid_out), 64'h0);
      check_val("rst_instr",     64'(instr_out),       64'h0);
      check_val("rst_instr_pc",  instr_pc_out,         64'h0);
      check_val("rst_addr",      imem_addr_out,        64'h0);
`ifdef PC_MISALIGN_TRAP_EN
      check_val("rst_trap",      64'(misalign_trap_out), 64'h0);
`endif

      // Sequential fetch with a zero-latency memory: a 3-cycle period each.
      reset           = 1'b0;
      imem_ready_in   = 1'b1;
      imem_valid_in   = 1'b1;
      decode_ready_in = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         imem_rdata_in = 32'hC0DE_0000 + 32'(k);
         check_val("seq_req",      64'(imem_req_out),    64'h1);
         check_val("seq_addr",     imem_addr_out,        64'(4 * k));
         step();
         check_val("seq_wait_req", 64'(imem_req_out),    64'h0);
         step();
         check_val("seq_ivalid",   64'(instr_valid_out), 64'h1);
         check_val("seq_instr",    64'(instr_out),       64'(32'hC0DE_0000 + 32'(k)));
         check_val("seq_instr_pc", instr_pc_out,         64'(4 * k));
         step();
      end

      // Decode stalls for 5 cycles in HOLD.
      decode_ready_in = 1'b0;
      imem_rdata_in   = 32'h1234_5678;
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         check_val("stall_ivalid",   64'(instr_valid_out), 64'h1);
         check_val("stall_instr",    64'(instr_out),       64'h1234_5678);
         check_val("stall_instr_pc", instr_pc_out,         64'hC);
         check_val("stall_req",      64'(imem_req_out),    64'h0);
         step();
      end
      decode_ready_in = 1'b1;
      step();
      check_val("stall_next_addr", imem_addr_out, 64'h10);

      // Redirect in WAIT, with the data returning on the following cycle.
      imem_valid_in = 1'b0;
      step();
      PC_src_in        = 1'b1;
      branch_target_in = 64'h100;
      step();
      check_val("rwait_req", 64'(imem_req_out), 64'h0);
      PC_src_in     = 1'b0;
      imem_valid_in = 1'b1;
      imem_rdata_in = 32'h0000_DEAD;
      step();
      check_val("rwait_ivalid", 64'(instr_valid_out), 64'h0);
      check_val("rwait_req2",   64'(imem_req_out),    64'h1);
      check_val("rwait_addr",   imem_addr_out,        64'h100);

      // Redirect in the same cycle that FETCH is accepted.
      imem_valid_in    = 1'b0;
      PC_src_in        = 1'b1;
      branch_target_in = 64'h200;
      step();
      PC_src_in     = 1'b0;
      imem_valid_in = 1'b1;
      imem_rdata_in = 32'h0000_0BAD;
      step();
      check_val("racc_ivalid", 64'(instr_valid_out), 64'h0);
      check_val("racc_addr",   imem_addr_out,        64'h200);

      // Redirect in WAIT in the same cycle that the data returns.
      imem_valid_in = 1'b0;
      step();
      PC_src_in        = 1'b1;
      branch_target_in = 64'h300;
      imem_valid_in    = 1'b1;
      step();
      PC_src_in = 1'b0;
      check_val("rsame_ivalid", 64'(instr_valid_out), 64'h0);
      check_val("rsame_addr",   imem_addr_out,        64'h300);

      // Redirect in HOLD retracts the held instruction.
      decode_ready_in = 1'b0;
      imem_rdata_in   = 32'h0BAD_F00D;
      step();
      step();
      check_val("rhold_ivalid0",  64'(instr_valid_out), 64'h1);
      check_val("rhold_instr_pc", instr_pc_out,         64'h300);
      PC_src_in        = 1'b1;
      branch_target_in = 64'h400;
      step();
      PC_src_in = 1'b0;
      check_val("rhold_ivalid1", 64'(instr_valid_out), 64'h0);
      check_val("rhold_addr",    imem_addr_out,        64'h400);

      // Redirect in FETCH while the request is not accepted.
      imem_ready_in    = 1'b0;
      PC_src_in        = 1'b1;
      branch_target_in = 64'h500;
      step();
      check_val("rnoacc_req",  64'(imem_req_out), 64'h1);
      check_val("rnoacc_addr", imem_addr_out,     64'h500);

      // The pc wraps to 0 when it steps past the top of the address space.
      branch_target_in = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      check_val("wrap_addr0", imem_addr_out, 64'hFFFF_FFFF_FFFF_FFFC);
      PC_src_in       = 1'b0;
      imem_ready_in   = 1'b1;
      decode_ready_in = 1'b1;
      step();
      step();
      check_val("wrap_instr_pc", instr_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
      check_val("wrap_req",  64'(imem_req_out), 64'h1);
      check_val("wrap_addr", imem_addr_out,     64'h0);

      // Redirect to a misaligned target.
      imem_ready_in    = 1'b0;
      PC_src_in        = 1'b1;
      branch_target_in = 64'h102;
      step();
      PC_src_in = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      check_val("mis_trap", 64'(misalign_trap_out), 64'h1);
      check_val("mis_req",  64'(imem_req_out),      64'h0);
      imem_ready_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_val("mis_trap_hold", 64'(misalign_trap_out), 64'h1);
         check_val("mis_req_hold",  64'(imem_req_out),      64'h0);
         check_val("mis_ivalid",    64'(instr_valid_out),   64'h0);
      end
`else
      check_val("mis_req",  64'(imem_req_out), 64'h1);
      check_val("mis_addr", imem_addr_out,     64'h100);
`endif

      // Reset in WAIT. The late imem_valid_in that follows must be ignored.
      reset = 1'b1;
      step();
      reset         = 1'b0;
      imem_ready_in = 1'b1;
      imem_valid_in = 1'b0;
      step();
      step();
      check_val("rstw_wait_req", 64'(imem_req_out), 64'h0);
      reset         = 1'b1;
      imem_valid_in = 1'b1;
      imem_rdata_in = 32'hFEED_FACE;
      step();
      check_val("rstw_req",      64'(imem_req_out),    64'h0);
      check_val("rstw_ivalid",   64'(instr_valid_out), 64'h0);
      check_val("rstw_instr",    64'(instr_out),       64'h0);
      check_val("rstw_instr_pc", instr_pc_out,         64'h0);
`ifdef PC_MISALIGN_TRAP_EN
      check_val("rstw_trap",     64'(misalign_trap_out), 64'h0);
`endif
      reset = 1'b0;
      step();
      check_val("rstw_late_ivalid", 64'(instr_valid_out), 64'h0);
      check_val("rstw_late_req",    64'(imem_req_out),    64'h1);
      check_val("rstw_late_addr",   imem_addr_out,        64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 64, width of the program counter and all address ports.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 PC_src_in  input  1  redirect request from the branch decision stage; 1 = take branch_target_in.
REQ-007 branch_target_in  input  PC_WIDTH  redirect target, valid when PC_src_in=1.
REQ-008 imem_req_out  output  1  instruction-memory request valid.
REQ-009 imem_addr_out  output  PC_WIDTH  instruction-memory request address.
REQ-010 imem_ready_in  input  1  memory accepts the request this cycle.
REQ-011 imem_valid_in  input  1  read data returned this cycle.
REQ-012 imem_rdata_in  input  32  returned instruction word.
REQ-013 instr_valid_out  output  1  instr_out/instr_pc_out valid toward decode.
REQ-014 instr_out  output  32  fetched instruction.
REQ-015 instr_pc_out  output  PC_WIDTH  address of instr_out.
REQ-016 decode_ready_in  input  1  decode consumes instruction when instr_valid_out=1.
REQ-017 misalign_trap_out  output  1  misaligned-target trap; present only with PC_MISALIGN_TRAP_EN.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT, HOLD (plus TRAP with macro); IDLE -> FETCH unconditionally the cycle after reset release.
REQ-019 FETCH: imem_req_out=1, imem_addr_out=pc; on imem_ready_in -> WAIT, fetch_pc <= pc, pc <= pc+4; else remain in FETCH.
REQ-020 pc+4 wraps modulo 2^PC_WIDTH; no overflow flag.
REQ-021 WAIT: imem_req_out=0; on imem_valid_in with kill=0 -> HOLD, capture instr_out <= imem_rdata_in, instr_pc_out <= fetch_pc; imem_valid_in outside WAIT is ignored.
REQ-022 HOLD: instr_valid_out=1, outputs stable; on decode_ready_in -> FETCH next cycle (one-instruction-in-flight, 3-cycle minimum fetch period with zero-latency memory).
REQ-023 Redirect (PC_src_in=1) has priority over pc+4: pc <= branch_target_in in every state except IDLE/TRAP.
REQ-024 Redirect in FETCH without imem_ready_in: stay FETCH; imem_addr_out shows target next cycle (address change while unaccepted is legal).
REQ-025 Redirect in FETCH with imem_ready_in same cycle: -> WAIT with kill=1.
REQ-026 Redirect in WAIT: kill <= 1; if imem_valid_in same cycle, data dropped, -> FETCH, kill cleared.
REQ-027 WAIT with kill=1 and imem_valid_in: data dropped, kill <= 0, -> FETCH; instr_valid_out never asserted for killed data.
REQ-028 Redirect in HOLD (with or without decode_ready_in): instruction retracted, instr_valid_out=0 next cycle, -> FETCH.

Reset
REQ-029 Reset: pc=RESET_PC, state IDLE, kill=0, imem_req_out=0, instr_valid_out=0, instr_out=0, instr_pc_out=0, misalign_trap_out=0.
REQ-030 Reset mid-transaction (WAIT) abandons it; the late imem_valid_in is ignored since state is not WAIT.

Configuration
REQ-031 Macro PC_MISALIGN_TRAP_EN defined: redirect with branch_target_in[1:0]!=0 -> TRAP, misalign_trap_out=1 held, imem_req_out=0, instr_valid_out=0 until reset; pc loads the target unmodified.
REQ-032 Macro undefined: no misalign_trap_out port, no TRAP state; target loaded with bits [1:0] forced to 0.

Structure
REQ-033 Shared package holds FSM state enum, INSTR_WIDTH=32 and PC_INCR=4 constants.
REQ-034 No sub-module; single flat module.

Verification
REQ-035 Reset, imem_ready/valid tied 1, decode_ready 1 -> addresses 0,4,8 issued; instr_pc_out 0,4,8 in order.
REQ-036 decode_ready_in=0 for 5 cycles in HOLD -> instr_out/instr_pc_out stable, no new imem request.
REQ-037 Redirect to 0x100 in WAIT, data returns next cycle -> data dropped, next request address 0x100.
REQ-038 Redirect to 0x200 same cycle as imem_ready_in in FETCH -> returned word discarded, next request 0x200.
REQ-039 pc=2^PC_WIDTH-4 fetch -> next request address 0.
REQ-040 With macro, redirect to 0x102 -> misalign_trap_out=1, no further requests; without macro -> request address 0x100.
